// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, zero register,
// default MULT/DIV latency and the packed stage-control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        HALT    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         MD_LAT_DEF = 4;
    localparam int         CNT_W_DEF  = 3;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_clr;
        logic idex_clr;
        logic exmem_clr;
        logic halted;
        logic md_busy;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_HALT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Front end and EX held; a bubble is pushed into EX/MEM while MULT/DIV grinds.
    function automatic ctrl_t md_freeze();
        ctrl_t c;
        c           = CTRL_RUN;
        c.pc_en     = 1'b0;
        c.ifid_en   = 1'b0;
        c.idex_en   = 1'b0;
        c.exmem_clr = 1'b1;
        c.md_busy   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect_lu.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
// Purely combinational so the forwarding unit can reuse it.
module hazard_detect_lu
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_use_rs_i,
    input  logic       id_use_rt_i,
    input  logic       ex_memtoreg_i,
    input  logic [4:0] ex_wbreg_i,
    output logic       lu_o
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = id_use_rs_i && (id_rs_i == ex_wbreg_i);
    assign rt_hit_s = id_use_rt_i && (id_rt_i == ex_wbreg_i);
    assign lu_o     = ex_memtoreg_i && (ex_wbreg_i != REG_ZERO) && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: stage EN/CLR and PC enable for load-use, branch flush,
// MULT/DIV stretch and SYSCALL halt. Optional counters under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_memtoreg,
    input  logic [4:0]  ex_wbreg,
    input  logic        ex_branch_taken,
    input  logic        ex_md,
    input  logic        mem_syscall_halt,
    input  logic        go,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        exmem_clr,
    output logic        halted,
    output logic        md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam bit             MD_STALL = (MD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = MD_STALL ? CNT_W'(MD_LAT - 2) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_s;
    ctrl_t            ctl_s;

    hazard_detect_lu u_lu (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_use_rs_i   (id_use_rs),
        .id_use_rt_i   (id_use_rt),
        .ex_memtoreg_i (ex_memtoreg),
        .ex_wbreg_i    (ex_wbreg),
        .lu_o          (lu_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Halt wins over MULT/DIV entry so the stretch replays in full after resume.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_syscall_halt) begin
                    state_d = HALT;
                end else if (ex_md && MD_STALL) begin
                    state_d = MD_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            MD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                if (go) begin
                    state_d = RUN;
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ctl_s = CTRL_RUN;
        if (rst) begin
            ctl_s = CTRL_RUN;
        end else begin
            case (state_q)
                RUN: begin
                    // A taken branch makes the ID instruction wrong-path, so lu is moot.
                    if (ex_branch_taken) begin
                        ctl_s.ifid_clr = 1'b1;
                        ctl_s.idex_clr = 1'b1;
                    end else if (lu_s) begin
                        ctl_s.pc_en    = 1'b0;
                        ctl_s.ifid_en  = 1'b0;
                        ctl_s.idex_clr = 1'b1;
                    end else if (ex_md && MD_STALL) begin
                        ctl_s = md_freeze();
                    end else begin
                        ctl_s = CTRL_RUN;
                    end
                end
                MD_WAIT: begin
                    if (cnt_q != '0) begin
                        ctl_s = md_freeze();
                    end else begin
                        ctl_s = CTRL_RUN;
                    end
                end
                HALT:    ctl_s = CTRL_HALT;
                default: ctl_s = CTRL_RUN;
            endcase
        end
    end

    assign pc_en     = ctl_s.pc_en;
    assign ifid_en   = ctl_s.ifid_en;
    assign idex_en   = ctl_s.idex_en;
    assign exmem_en  = ctl_s.exmem_en;
    assign memwb_en  = ctl_s.memwb_en;
    assign ifid_clr  = ctl_s.ifid_clr;
    assign idex_clr  = ctl_s.idex_clr;
    assign exmem_clr = ctl_s.exmem_clr;
    assign halted    = ctl_s.halted;
    assign md_busy   = ctl_s.md_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!ctl_s.pc_en && (state_q != HALT)) begin
                stall_q <= stall_q + 32'd1;
            end
            if ((state_q == RUN) && ex_branch_taken) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed test-plan steps followed by
// randomized traffic against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_wbreg;
    logic       id_use_rs, id_use_rt, ex_memtoreg, ex_branch_taken, ex_md;
    logic       mem_syscall_halt, go;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_clr, idex_clr, exmem_clr, halted, md_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
    logic [31:0] m_stall, m_flush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: halted flag plus number of cycles left in the MULT/DIV wait phase
    // (the final one being the release cycle).
    bit         m_halt;
    int         m_wait;
    logic [9:0] exp_v;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_use_rs        (id_use_rs),
        .id_use_rt        (id_use_rt),
        .ex_memtoreg      (ex_memtoreg),
        .ex_wbreg         (ex_wbreg),
        .ex_branch_taken  (ex_branch_taken),
        .ex_md            (ex_md),
        .mem_syscall_halt (mem_syscall_halt),
        .go               (go),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exmem_en         (exmem_en),
        .memwb_en         (memwb_en),
        .ifid_clr         (ifid_clr),
        .idex_clr         (idex_clr),
        .exmem_clr        (exmem_clr),
        .halted           (halted),
        .md_busy          (md_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Order: pc ifid idex exmem memwb | ifid_clr idex_clr exmem_clr | halted md_busy
    function automatic logic [9:0] model_out();
        logic       lu;
        logic [9:0] o;
        lu = ex_memtoreg && (ex_wbreg != 5'd0) &&
             ((id_use_rs && id_rs == ex_wbreg) || (id_use_rt && id_rt == ex_wbreg));
        o = 10'b11111_000_00;
        if (rst)                            o = 10'b11111_000_00;
        else if (m_halt)                    o = 10'b00000_000_10;
        else if (m_wait > 1)                o = 10'b00011_001_01;
        else if (m_wait == 1)               o = 10'b11111_000_00;
        else if (ex_branch_taken)           o = 10'b11111_110_00;
        else if (lu)                        o = 10'b00111_010_00;
        else if (ex_md && MD_LAT > 1)       o = 10'b00011_001_01;
        return o;
    endfunction

    task automatic settle(input string tag);
        #2;
        exp_v = model_out();
        chk(tag, {22'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_clr, idex_clr, exmem_clr, halted, md_busy}, {22'd0, exp_v});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cycles, m_stall);
        chk({tag, "_flush_cnt"}, flush_count, m_flush);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
        if (rst) begin
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else begin
            if (!exp_v[9] && !m_halt) m_stall = m_stall + 32'd1;
            if (!m_halt && m_wait == 0 && ex_branch_taken) m_flush = m_flush + 32'd1;
        end
`endif
        if (rst) begin
            m_halt = 1'b0;
            m_wait = 0;
        end else if (m_halt) begin
            if (go) m_halt = 1'b0;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
        end else if (mem_syscall_halt) begin
            m_halt = 1'b1;
        end else if (ex_md && MD_LAT > 1) begin
            m_wait = MD_LAT - 1;
        end
        #1;
    endtask

    task automatic step(input string tag);
        settle(tag);
        tick();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_wbreg = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memtoreg = 1'b0;
        ex_branch_taken = 1'b0; ex_md = 1'b0; mem_syscall_halt = 1'b0; go = 1'b0;
    endtask

    initial begin
        m_halt = 1'b0;
        m_wait = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_stall = 32'd0;
        m_flush = 32'd0;
`endif
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        // Reset cycle shows the RUN default.
        settle("reset");
        chk("reset_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        rst = 1'b0;
        step("idle");

        // Load-use bubble then recovery.
        ex_memtoreg = 1'b1; ex_wbreg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        settle("lu");
        chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lu_idex_clr", {31'd0, idex_clr}, 32'd1);
        tick();
        ex_memtoreg = 1'b0;
        settle("lu_after");
        chk("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
        tick();

        // Zero register never stalls.
        ex_memtoreg = 1'b1; ex_wbreg = 5'd0; id_rs = 5'd0;
        settle("lu_zero");
        chk("lu_zero_pc_en", {31'd0, pc_en}, 32'd1);
        tick();

        // Branch squashes, lu ignored.
        ex_wbreg = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
        settle("br_lu");
        chk("br_lu_ifid_clr", {31'd0, ifid_clr}, 32'd1);
        chk("br_lu_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        idle_inputs();

        // MULT/DIV stretch: MD_LAT-1 stall cycles then one release cycle.
        ex_md = 1'b1;
        for (int i = 0; i < MD_LAT; i++) begin
            settle("md");
            chk("md_busy_seq", {31'd0, md_busy}, (i < MD_LAT - 1) ? 32'd1 : 32'd0);
            chk("md_pc_en_seq", {31'd0, pc_en}, (i < MD_LAT - 1) ? 32'd0 : 32'd1);
            tick();
        end
        ex_md = 1'b0;
        step("md_done");

        // SYSCALL halt: detection cycle advances, then frozen until go.
        mem_syscall_halt = 1'b1;
        settle("sys_detect");
        chk("sys_detect_memwb", {31'd0, memwb_en}, 32'd1);
        tick();
        mem_syscall_halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle("halt_hold");
            chk("halt_flag", {31'd0, halted}, 32'd1);
            tick();
        end
        go = 1'b1;
        settle("halt_go");
        chk("halt_go_frozen", {31'd0, memwb_en}, 32'd0);
        tick();
        go = 1'b0;
        settle("resumed");
        chk("resumed_halted", {31'd0, halted}, 32'd0);
        tick();

        // Reset during HALT.
        mem_syscall_halt = 1'b1;
        step("sys2");
        mem_syscall_halt = 1'b0;
        step("halt2");
        rst = 1'b1;
        step("rst_in_halt");
        rst = 1'b0;
        settle("after_halt_rst");
        chk("after_halt_rst_halted", {31'd0, halted}, 32'd0);
        tick();

        // Reset in MD_WAIT with one stall left.
        ex_md = 1'b1;
        step("md2_a");
        step("md2_b");
        rst = 1'b1;
        step("rst_in_md");
        rst = 1'b0; ex_md = 1'b0;
        settle("after_md_rst");
        chk("after_md_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("after_md_rst_pc_en", {31'd0, pc_en}, 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        chk("after_md_rst_stall0", stall_cycles, 32'd0);
`endif
        tick();

        // Randomized traffic with small register indices to hit hazards often.
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 63) == 0);
            id_rs            = 5'($urandom_range(0, 3));
            id_rt            = 5'($urandom_range(0, 3));
            ex_wbreg         = 5'($urandom_range(0, 3));
            id_use_rs        = 1'($urandom_range(0, 1));
            id_use_rt        = 1'($urandom_range(0, 1));
            ex_md            = ($urandom_range(0, 7) == 0);
            ex_memtoreg      = !ex_md && ($urandom_range(0, 1) == 1);
            ex_branch_taken  = !ex_md && ($urandom_range(0, 5) == 0);
            mem_syscall_halt = ($urandom_range(0, 15) == 0);
            go               = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
